// File: rtl/shift_reg_serial_deserializer_pkg.sv
// Purpose : shared constants and types for the serial-to-parallel deserializer.
// Latency : n/a (declarations only).
// Backpressure : n/a (declarations only).
package shift_reg_serial_deserializer_pkg;

  // Default word size in bits; any WIDTH >= 2 is supported.
  localparam int DESER_WIDTH_DEFAULT = 8;

  // One-entry output holding register occupancy.
  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

  // Bits needed for a bit counter spanning 0..width-1.
  function automatic int deser_cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/deser_hold_reg.sv
// Purpose : one-entry output holding register with valid/ready handshake and sticky overrun flag.
// Latency : a completed word appears on dat_o/vld_o the cycle after the edge that delivers it.
// Backpressure : while full and not accepted, an arriving word is dropped and ovr_o is set.
//
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   word_vld_i/_dat_i : single-cycle pulse carrying a freshly assembled word
//   rdy_i             : consumer ready; transfer occurs when vld_o && rdy_i
//   ovr_clr_i         : clears ovr_o (a simultaneous new overrun wins)
//   dat_o, vld_o      : registered held word and its valid
//   ovr_o             : sticky overrun flag
module deser_hold_reg
  import shift_reg_serial_deserializer_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             word_vld_i,
  input  logic [WIDTH-1:0] word_dat_i,
  input  logic             rdy_i,
  input  logic             ovr_clr_i,
  output logic [WIDTH-1:0] dat_o,
  output logic             vld_o,
  output logic             ovr_o
);

  hold_state_e      state_q, state_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             ovr_q, ovr_d;
  logic             accept;
  logic             ovr_set;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= HOLD_EMPTY;
      dat_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    ovr_set = 1'b0;
    accept  = (state_q == HOLD_FULL) && rdy_i;

    case (state_q)
      HOLD_EMPTY: begin
        if (word_vld_i) begin
          state_d = HOLD_FULL;
          dat_d   = word_dat_i;
        end
      end
      HOLD_FULL: begin
        if (word_vld_i) begin
          // The outgoing word leaves on this same edge, so the new word
          // slides straight in with no empty cycle in between.
          if (accept) begin
            dat_d = word_dat_i;
          end else begin
            ovr_set = 1'b1;
          end
        end else if (accept) begin
          state_d = HOLD_EMPTY;
        end
      end
    endcase

    // Setting has priority over clearing so a same-edge overrun is never lost.
    ovr_d = ovr_set | (ovr_q & ~ovr_clr_i);
  end

  assign dat_o = dat_q;
  assign vld_o = (state_q == HOLD_FULL);
  assign ovr_o = ovr_q;

endmodule

// File: rtl/shift_reg_serial_deserializer.sv
// Purpose : MSB-first serial-to-parallel deserializer with SYNC word alignment.
// Latency : PO/PV valid the cycle after the edge that samples the last bit of a word.
// Backpressure : one-entry holding register; a word completing while the held word is not taken is dropped and OVR set.
//
// Ports:
//   C, R     : clock, synchronous active-high reset
//   SI, SE   : serial data bit and shift enable (SI sampled only when SE=1)
//   SYNC     : marks the current bit position as the start of a new word
//   PO, PV   : assembled parallel word and its valid
//   PR       : consumer ready
//   OVR      : sticky overrun flag, cleared by OVR_CLR or R
module shift_reg_serial_deserializer
  import shift_reg_serial_deserializer_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH_DEFAULT
) (
  input  logic             C,
  input  logic             R,
  input  logic             SI,
  input  logic             SE,
  input  logic             SYNC,
  output logic [WIDTH-1:0] PO,
  output logic             PV,
  input  logic             PR,
  output logic             OVR,
  input  logic             OVR_CLR
);

  localparam int             CW       = deser_cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shifted;
  logic             word_vld;

  always_ff @(posedge C) begin
    if (R) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign shifted = {shreg_q[WIDTH-2:0], SI};

  always_comb begin
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    word_vld = 1'b0;

    if (SYNC) begin
      // Realignment drops any partial word. With SE=1 the current bit is
      // the first bit of the new word, so the counter resumes at 1 and no
      // completion is signalled even if the old count was at the last bit.
      if (SE) begin
        shreg_d = {{(WIDTH-1){1'b0}}, SI};
        cnt_d   = CW'(1);
      end else begin
        shreg_d = '0;
        cnt_d   = '0;
      end
    end else if (SE) begin
      shreg_d = shifted;
      if (cnt_q == CNT_LAST) begin
        cnt_d    = '0;
        word_vld = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // The completed word is the shifted value itself, so it reaches the
  // holding register on the same edge that samples the last bit.
  deser_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk_i      (C),
    .rst_i      (R),
    .word_vld_i (word_vld),
    .word_dat_i (shifted),
    .rdy_i      (PR),
    .ovr_clr_i  (OVR_CLR),
    .dat_o      (PO),
    .vld_o      (PV),
    .ovr_o      (OVR)
  );

endmodule

// File: tb/tb_shift_reg_serial_deserializer.sv
// Purpose : self-checking bench for shift_reg_serial_deserializer (WIDTH=8).
// Latency : checks PO/PV one cycle after the last-bit edge.
// Backpressure : exercises PR=0 hold, overrun, same-edge accept-and-refill.
module tb_shift_reg_serial_deserializer;

  localparam int W = 8;

  logic         C;
  logic         R;
  logic         SI;
  logic         SE;
  logic         SYNC;
  logic [W-1:0] PO;
  logic         PV;
  logic         PR;
  logic         OVR;
  logic         OVR_CLR;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: bits gathered so far, the held word, flags.
  int           m_bits[$];
  logic [W-1:0] m_po;
  logic         m_pv;
  logic         m_ovr;

  shift_reg_serial_deserializer #(.WIDTH(W)) dut (
    .C       (C),
    .R       (R),
    .SI      (SI),
    .SE      (SE),
    .SYNC    (SYNC),
    .PO      (PO),
    .PV      (PV),
    .PR      (PR),
    .OVR     (OVR),
    .OVR_CLR (OVR_CLR)
  );

  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  // Model of one clock edge, phrased as "collect bits, emit a word every W bits".
  task automatic model_edge(input logic si, se, sync, pr, clr, r);
    logic         done;
    logic         set;
    logic [W-1:0] word;
    logic         acc;
    done = 1'b0;
    set  = 1'b0;
    word = '0;
    if (r) begin
      m_bits.delete();
      m_po  = '0;
      m_pv  = 1'b0;
      m_ovr = 1'b0;
    end else begin
      acc = m_pv && pr;
      if (sync) begin
        m_bits.delete();
        if (se) m_bits.push_back(int'(si));
      end else if (se) begin
        m_bits.push_back(int'(si));
        if (m_bits.size() == W) begin
          for (int i = 0; i < W; i++) word = W'((int'(word) * 2 + m_bits[i]) % (1 << W));
          m_bits.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        if (!m_pv || acc) begin
          m_po = word;
          m_pv = 1'b1;
        end else begin
          set = 1'b1;
        end
      end else if (acc) begin
        m_pv = 1'b0;
      end
      m_ovr = set ? 1'b1 : (clr ? 1'b0 : m_ovr);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, clock it, step the model, settle.
  task automatic step(input logic si, se, sync, pr, clr, r);
    @(negedge C);
    SI = si; SE = se; SYNC = sync; PR = pr; OVR_CLR = clr; R = r;
    @(posedge C);
    model_edge(si, se, sync, pr, clr, r);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic pr);
    for (int i = W - 1; i >= 0; i--) step(w[i], 1'b1, 1'b0, pr, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    n_tests++; if (PO !== 8'h00) begin n_fail++; $display("FAIL reset_po: got %h want 00", PO); end
    n_tests++; if (PV !== 1'b0) begin n_fail++; $display("FAIL reset_pv: got %b want 0", PV); end
    n_tests++; if (OVR !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", OVR); end
  endtask

  task automatic test_basic();
    logic [W-1:0] w;
    w = 8'hA5;
    do_reset();
    for (int i = W - 1; i >= 0; i--) begin
      step(w[i], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      if (i > 0) begin
        n_tests++; if (PV !== 1'b0) begin n_fail++; $display("FAIL basic_early_pv bit%0d: got %b want 0", i, PV); end
      end
    end
    n_tests++; if (PO !== 8'hA5) begin n_fail++; $display("FAIL basic_po: got %h want a5", PO); end
    n_tests++; if (PV !== 1'b1) begin n_fail++; $display("FAIL basic_pv: got %b want 1", PV); end
    n_tests++; if (OVR !== 1'b0) begin n_fail++; $display("FAIL basic_ovr: got %b want 0", OVR); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_tests++; if (PV !== 1'b0) begin n_fail++; $display("FAIL basic_pv_one_cycle: got %b want 0", PV); end
  endtask

  task automatic test_se_gaps();
    logic [W-1:0] w;
    w = 8'h3C;
    do_reset();
    for (int i = W - 1; i >= 0; i--) begin
      step(w[i], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      if (i > 0) begin
        n_tests++; if (PV !== 1'b0) begin n_fail++; $display("FAIL segap_early_pv bit%0d: got %b want 0", i, PV); end
        // Noise on SI while SE=0 must not be shifted in.
        step(1'($urandom_range(1)), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (PV !== 1'b0) begin n_fail++; $display("FAIL segap_idle_pv bit%0d: got %b want 0", i, PV); end
      end
    end
    n_tests++; if (PV !== 1'b1) begin n_fail++; $display("FAIL segap_pv: got %b want 1", PV); end
    n_tests++; if (PO !== 8'h3C) begin n_fail++; $display("FAIL segap_po: got %h want 3c", PO); end
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_overrun();
    do_reset();
    send_word(8'h11, 1'b0);
    n_tests++; if (PO !== 8'h11 || PV !== 1'b1) begin n_fail++; $display("FAIL ovr_first: got po=%h pv=%b want po=11 pv=1", PO, PV); end
    send_word(8'h22, 1'b0);
    n_tests++; if (PO !== 8'h11) begin n_fail++; $display("FAIL ovr_po_kept: got %h want 11", PO); end
    n_tests++; if (PV !== 1'b1) begin n_fail++; $display("FAIL ovr_pv: got %b want 1", PV); end
    n_tests++; if (OVR !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", OVR); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_tests++; if (PV !== 1'b0) begin n_fail++; $display("FAIL ovr_drain_pv: got %b want 0", PV); end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_tests++; if (OVR !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", OVR); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_tests++; if (OVR !== 1'b0) begin n_fail++; $display("FAIL ovr_clr: got %b want 0", OVR); end
  endtask

  task automatic test_ovr_clr_race();
    logic [W-1:0] w;
    w = 8'h34;
    do_reset();
    send_word(8'h12, 1'b0);
    for (int i = W - 1; i >= 0; i--) step(w[i], 1'b1, 1'b0, 1'b0, (i == 0), 1'b0);
    n_tests++; if (OVR !== 1'b1) begin n_fail++; $display("FAIL race_ovr: got %b want 1", OVR); end
    n_tests++; if (PO !== 8'h12) begin n_fail++; $display("FAIL race_po: got %h want 12", PO); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w;
    w = 8'h77;
    do_reset();
    send_word(8'h66, 1'b0);
    n_tests++; if (PO !== 8'h66 || PV !== 1'b1) begin n_fail++; $display("FAIL b2b_held: got po=%h pv=%b want po=66 pv=1", PO, PV); end
    for (int i = W - 1; i >= 0; i--) step(w[i], 1'b1, 1'b0, (i == 0), 1'b0, 1'b0);
    n_tests++; if (PO !== 8'h77) begin n_fail++; $display("FAIL b2b_po: got %h want 77", PO); end
    n_tests++; if (PV !== 1'b1) begin n_fail++; $display("FAIL b2b_pv: got %b want 1", PV); end
    n_tests++; if (OVR !== 1'b0) begin n_fail++; $display("FAIL b2b_ovr: got %b want 0", OVR); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_tests++; if (PV !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", PV); end
  endtask

  task automatic test_sync();
    int pv_seen;
    // Resync after 5 bits; SYNC bit becomes the MSB of the new word.
    do_reset();
    pv_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      pv_seen += int'(PV);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    pv_seen += int'(PV);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      pv_seen += int'(PV);
    end
    n_tests++; if (pv_seen != 0) begin n_fail++; $display("FAIL sync_no_stale_word: got %0d words want 0", pv_seen); end
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_tests++; if (PO !== 8'h80 || PV !== 1'b1) begin n_fail++; $display("FAIL sync_po: got po=%h pv=%b want po=80 pv=1", PO, PV); end
    // SYNC on the bit that would have completed a word: no completion.
    do_reset();
    for (int i = 0; i < W - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    n_tests++; if (PV !== 1'b0) begin n_fail++; $display("FAIL sync_last_bit_pv: got %b want 0", PV); end
    for (int i = 0; i < W - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_tests++; if (PO !== 8'hFF || PV !== 1'b1) begin n_fail++; $display("FAIL sync_last_bit_word: got po=%h pv=%b want po=ff pv=1", PO, PV); end
    // SYNC with SE=0 restarts at bit 0; held word and flags untouched.
    do_reset();
    send_word(8'h9B, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++; if (PO !== 8'h9B || PV !== 1'b1 || OVR !== 1'b0) begin n_fail++; $display("FAIL sync_keeps_hold: got po=%h pv=%b ovr=%b want po=9b pv=1 ovr=0", PO, PV, OVR); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_word(8'h5A, 1'b1);
    n_tests++; if (PO !== 8'h5A || PV !== 1'b1) begin n_fail++; $display("FAIL sync_se0_word: got po=%h pv=%b want po=5a pv=1", PO, PV); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_word(8'hC3, 1'b0);
    send_word(8'h3C, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (PV !== 1'b1 || OVR !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got pv=%b ovr=%b want pv=1 ovr=1", PV, OVR); end
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    n_tests++; if (PV !== 1'b0 || PO !== 8'h00 || OVR !== 1'b0) begin n_fail++; $display("FAIL rmid_reset: got po=%h pv=%b ovr=%b want po=00 pv=0 ovr=0", PO, PV, OVR); end
    for (int i = 0; i < W - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_tests++; if (PV !== 1'b0) begin n_fail++; $display("FAIL rmid_restart_pv: got %b want 0", PV); end
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_tests++; if (PO !== 8'hFF || PV !== 1'b1) begin n_fail++; $display("FAIL rmid_word: got po=%h pv=%b want po=ff pv=1", PO, PV); end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(1)),
           ($urandom_range(3) != 0),
           ($urandom_range(22) == 0),
           ($urandom_range(2) != 0),
           ($urandom_range(16) == 0),
           ($urandom_range(150) == 0));
      n_tests++;
      if (PV !== m_pv || OVR !== m_ovr || (m_pv && PO !== m_po)) begin
        n_fail++;
        errs++;
        if (errs <= 10) $display("FAIL random cyc%0d: got po=%h pv=%b ovr=%b want po=%h pv=%b ovr=%b", n, PO, PV, OVR, m_po, m_pv, m_ovr);
      end
    end
  endtask

  initial begin
    R = 1'b1; SI = 1'b0; SE = 1'b0; SYNC = 1'b0; PR = 1'b0; OVR_CLR = 1'b0;
    m_po = '0; m_pv = 1'b0; m_ovr = 1'b0;
    test_reset();
    test_basic();
    test_se_gaps();
    test_overrun();
    test_ovr_clr_race();
    test_back_to_back();
    test_sync();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_reg_serial_deserializer.md
SHIFT_REG_SERIAL_DESERIALIZER -- requirements
Module: shift_reg_serial_deserializer

Interface
REQ-001 Parameter WIDTH, default 8: bits per word; the block SHALL support WIDTH >= 2.
REQ-002 C  input  1: single clock; all state SHALL update on the rising edge of C only.
REQ-003 R  input  1: reset, synchronous and active-high, sampled on the rising edge of C.
REQ-004 SI  input  1: serial data bit, MSB of each word first.
REQ-005 SE  input  1: shift enable; SI SHALL be sampled only on edges where SE=1.
REQ-006 SYNC  input  1: word alignment; marks the current bit position as the start of a new word.
REQ-007 PO  output  WIDTH: assembled parallel word; held stable while PV=1 and PR=0.
REQ-008 PV  output  1: PO valid.
REQ-009 PR  input  1: consumer ready; a word transfers on any edge where PV=1 and PR=1.
REQ-010 OVR  output  1: sticky overrun flag.
REQ-011 OVR_CLR  input  1: clears OVR.

Function
REQ-012 Assembly: on an edge with SE=1, the shift register SHALL load {shreg[WIDTH-2:0], SI}, and the bit counter SHALL increment.
REQ-013 Bit counter range: 0..WIDTH-1; the first sampled bit of a word lands in PO[WIDTH-1], the last in PO[0].
REQ-014 SE=0: the shift register and counter SHALL hold; the output handshake still operates.
REQ-015 Completion: an edge with SE=1 and counter=WIDTH-1 completes a word = {shreg[WIDTH-2:0], SI}; the counter SHALL wrap to 0.
REQ-016 Latency: PV SHALL rise on the edge that samples the last bit, i.e. PO/PV are valid in the cycle immediately after that edge.
REQ-017 Holding register states: EMPTY (PV=0) and FULL (PV=1).
  - EMPTY + completion -> FULL, PO loaded.
  - FULL + accept, no completion -> EMPTY.
  - FULL + accept + completion -> FULL, PO loaded with the new word; no bubble.
  - FULL + no accept + completion -> FULL, PO unchanged, new word discarded, OVR set.
REQ-018 PV SHALL NOT depend combinationally on PR; PO/PV SHALL be registered.
REQ-019 SYNC with SE=1: SI SHALL be taken as bit 0 of a new word, counter -> 1, and any partial word discarded; no completion occurs, even if counter was WIDTH-1.
REQ-020 SYNC with SE=0: counter -> 0 and the partial word is discarded.
REQ-021 SYNC SHALL NOT affect PO, PV or OVR.
REQ-022 OVR SHALL remain 1 until R or OVR_CLR.
REQ-023 OVR_CLR on the same edge as a new overrun: the set SHALL win (OVR=1).

Reset
REQ-024 On R=1 at an edge: shift register=0, counter=0, PO=0, PV=0, OVR=0.
REQ-025 R SHALL override SE, SYNC, PR and OVR_CLR on that edge.
REQ-026 A partial word or held word at reset SHALL be discarded; assembly restarts at bit 0 on the first SE edge after R deasserts.

Structure
REQ-027 A shared package SHALL hold the default WIDTH constant and the holding-register state encoding (EMPTY/FULL).
REQ-028 The one-entry output holding register with valid/ready and overrun detection SHALL be a sub-module, deser_hold_reg, parameterised by WIDTH.
REQ-029 The top level SHALL contain only the shift register, the bit counter and SYNC handling.

Verification
REQ-030 WIDTH=8, PR=1, SE=1, SI=1,0,1,0,0,1,0,1 -> PO=0xA5, PV=1 for exactly one cycle after the 8th edge, OVR=0.
REQ-031 SE toggling 1/0 every cycle while sending 0x3C -> PO=0x3C; PV rises one cycle after the 8th SE=1 edge; the 8 SE=0 cycles cause no shifts.
REQ-032 PR=0, send 0x11 then 0x22 back-to-back -> PO stays 0x11, PV=1, OVR=1 after the 16th bit; PR=1 -> PV=0 next cycle; OVR stays 1 until OVR_CLR.
REQ-033 PR asserted on the same edge 0x77 completes while 0x66 is held -> 0x66 transferred, next cycle PO=0x77, PV=1, OVR=0.
REQ-034 Send 5 bits, then SYNC=1 with SE=1 and SI=1, then 7 more bits 0,0,0,0,0,0,0 -> PO=0x80, and no word is produced from the discarded 5 bits.
REQ-035 R=1 after 4 bits with PV=1 -> PV=0, PO=0, OVR=0 next cycle; the following 8 bits 0xFF produce PO=0xFF.
